// File: rtl/alu_cmd_ctrl_if.sv
// Command/ALU/TX bundle for alu_cmd_ctrl. The master side is the controller; the slave side is the RX source, the ALU and the TX sink.
interface alu_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH  = 16
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [3:0]            alu_func;
  logic                  alu_en;
  logic [RES_WIDTH-1:0]  alu_result;
  logic                  alu_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  busy;
  logic                  err;

  modport master (
    input  rx_data, rx_valid, alu_result, alu_valid, tx_ready,
    output alu_a, alu_b, alu_func, alu_en, tx_data, tx_valid, busy, err
  );

  modport slave (
    output rx_data, rx_valid, alu_result, alu_valid, tx_ready,
    input  alu_a, alu_b, alu_func, alu_en, tx_data, tx_valid, busy, err
  );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Parses CC,A,B,F frames, fires the ALU for one cycle and returns the result low byte first.
// alu_en the cycle after F, tx_valid two cycles later; tx bytes hold until tx_ready.
module alu_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH  = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic           clk,
  input  logic           rst,
  alu_cmd_ctrl_if.master bus
);
  localparam logic [DATA_WIDTH-1:0] SYNC_BYTE = DATA_WIDTH'(8'hCC);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_A, S_GET_B, S_GET_F, S_EXEC, S_WAIT, S_TX_LO, S_TX_HI
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_b_q, tx_data_q, res_hi_q;
  logic [3:0]            alu_func_q;
  logic                  alu_en_q, tx_valid_q, err_q;
  logic [CW-1:0]         cnt_q;
  logic                  bad_func, overrun;

  assign bad_func = (bus.rx_data[DATA_WIDTH-1:4] != '0) || (bus.rx_data[3:0] == 4'hF);
  // Any byte arriving once the command is committed is dropped and flagged.
  assign overrun  = bus.rx_valid && (state_q inside {S_EXEC, S_WAIT, S_TX_LO, S_TX_HI});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_func_q <= '0;
      alu_en_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      res_hi_q   <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      alu_en_q <= 1'b0;
      err_q    <= overrun;
      case (state_q)
        S_IDLE: if (bus.rx_valid && bus.rx_data == SYNC_BYTE) state_q <= S_GET_A;
        S_GET_A: if (bus.rx_valid) begin
          alu_a_q <= bus.rx_data;
          state_q <= S_GET_B;
        end
        S_GET_B: if (bus.rx_valid) begin
          alu_b_q <= bus.rx_data;
          state_q <= S_GET_F;
        end
        S_GET_F: if (bus.rx_valid) begin
          if (bad_func) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            alu_func_q <= bus.rx_data[3:0];
            alu_en_q   <= 1'b1;
            state_q    <= S_EXEC;
          end
        end
        S_EXEC: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.alu_valid) begin
            res_hi_q   <= bus.alu_result[RES_WIDTH-1:DATA_WIDTH];
            tx_data_q  <= bus.alu_result[DATA_WIDTH-1:0];
            tx_valid_q <= 1'b1;
            state_q    <= S_TX_LO;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            // Overrun on this same cycle folds into the same single err pulse.
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_TX_LO: if (bus.tx_ready) begin
          tx_data_q <= res_hi_q;
          state_q   <= S_TX_HI;
        end
        S_TX_HI: if (bus.tx_ready) begin
          tx_valid_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.alu_func = alu_func_q;
  assign bus.alu_en   = alu_en_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.err      = err_q;
endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a registered ALU model and a TX sink monitor.
module tb_alu_cmd_ctrl;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_cmd_ctrl_if #(.DATA_WIDTH(8), .RES_WIDTH(16)) bus ();

  alu_cmd_ctrl #(.DATA_WIDTH(8), .RES_WIDTH(16), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Registered ALU model: one-cycle result after alu_en when responding.
  logic        model_resp;
  logic [15:0] model_res;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.alu_valid  <= 1'b0;
      bus.alu_result <= '0;
    end else begin
      bus.alu_valid <= bus.alu_en && model_resp;
      if (bus.alu_en) bus.alu_result <= model_res;
    end
  end

  int         en_cnt  = 0;
  int         err_cnt = 0;
  logic [7:0] en_a, en_b;
  logic [3:0] en_f;
  logic [7:0] txq[$];
  logic       stall   = 1'b0;
  logic [7:0] prev_dat;

  always @(negedge clk) begin
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (bus.alu_en) begin
        en_cnt++;
        en_a = bus.alu_a;
        en_b = bus.alu_b;
        en_f = bus.alu_func;
      end
      if (bus.err) err_cnt++;
      if (stall && bus.tx_valid) check("tx_hold", {24'd0, bus.tx_data}, {24'd0, prev_dat});
      stall    = bus.tx_valid && !bus.tx_ready;
      prev_dat = bus.tx_data;
      if (bus.tx_valid && bus.tx_ready) txq.push_back(bus.tx_data);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
    send_byte(8'hCC);
    send_byte(a);
    send_byte(b);
    send_byte(f);
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = !bus.busy && !bus.tx_valid;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  int         en0, err0, tx0, en_at, tv_at, err_at;
  logic [7:0] stream[6];
  logic [7:0] badf[2];

  initial begin
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.tx_ready = 1'b0;
    model_resp   = 1'b1;
    model_res    = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy",  {31'd0, bus.busy}, 32'd0);
    check("rst_txv",   {31'd0, bus.tx_valid}, 32'd0);
    check("rst_en",    {31'd0, bus.alu_en}, 32'd0);
    check("rst_err",   {31'd0, bus.err}, 32'd0);
    check("rst_alu_a", {24'd0, bus.alu_a}, 32'd0);

    // Basic command with latency measurement from the F-accepting edge.
    en0 = en_cnt; err0 = err_cnt; tx0 = txq.size();
    model_res = 16'h0008; bus.tx_ready = 1'b1;
    send_frame(8'h05, 8'h03, 8'h00);
    en_at = 0; tv_at = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.alu_en && en_at == 0) en_at = n;
      if (bus.tx_valid) begin
        tv_at = n;
        break;
      end
    end
    check("t1_en_lat", en_at, 1);
    check("t1_tv_lat", tv_at, 3);
    wait_idle("t1_idle");
    check("t1_en_cnt", en_cnt - en0, 1);
    check("t1_a", {24'd0, en_a}, 32'h05);
    check("t1_b", {24'd0, en_b}, 32'h03);
    check("t1_f", {28'd0, en_f}, 32'h0);
    check("t1_txn", txq.size() - tx0, 2);
    if (txq.size() - tx0 == 2) begin
      check("t1_lo", {24'd0, txq[tx0]}, 32'h08);
      check("t1_hi", {24'd0, txq[tx0+1]}, 32'h00);
    end
    check("t1_err", err_cnt - err0, 0);

    // Backpressure: low byte must hold while tx_ready is low.
    tx0 = txq.size(); model_res = 16'hFE01; bus.tx_ready = 1'b0;
    send_frame(8'hFF, 8'hFF, 8'h02);
    tv_at = 0;
    for (int n = 1; n <= 20 && tv_at == 0; n++) begin
      @(negedge clk);
      if (bus.tx_valid) tv_at = n;
    end
    check("t2_txv", {31'd0, bus.tx_valid}, 32'd1);
    check("t2_lo_now", {24'd0, bus.tx_data}, 32'h01);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 bus.tx_ready = 1'b1;
    wait_idle("t2_idle");
    check("t2_txn", txq.size() - tx0, 2);
    if (txq.size() - tx0 == 2) begin
      check("t2_lo", {24'd0, txq[tx0]}, 32'h01);
      check("t2_hi", {24'd0, txq[tx0+1]}, 32'hFE);
    end

    // Leading junk ignored before sync.
    tx0 = txq.size(); en0 = en_cnt; model_res = 16'h0005;
    stream = '{8'h12, 8'h34, 8'hCC, 8'h0A, 8'h02, 8'h03};
    foreach (stream[i]) send_byte(stream[i]);
    wait_idle("t3_idle");
    check("t3_en_cnt", en_cnt - en0, 1);
    check("t3_a", {24'd0, bus.alu_a}, 32'h0A);
    check("t3_b", {24'd0, bus.alu_b}, 32'h02);
    check("t3_f", {28'd0, bus.alu_func}, 32'h3);
    check("t3_txn", txq.size() - tx0, 2);
    if (txq.size() - tx0 == 2) begin
      check("t3_lo", {24'd0, txq[tx0]}, 32'h05);
      check("t3_hi", {24'd0, txq[tx0+1]}, 32'h00);
    end

    // Illegal function bytes.
    badf = '{8'h1F, 8'h0F};
    foreach (badf[i]) begin
      tx0 = txq.size(); en0 = en_cnt; err0 = err_cnt;
      send_frame(8'h01, 8'h02, badf[i]);
      repeat (4) @(negedge clk);
      check("t4_err", err_cnt - err0, 1);
      check("t4_no_en", en_cnt - en0, 0);
      check("t4_busy", {31'd0, bus.busy}, 32'd0);
      check("t4_no_tx", txq.size() - tx0, 0);
    end

    // ALU never answers: err exactly TIMEOUT+1 cycles after alu_en.
    tx0 = txq.size(); err0 = err_cnt; model_resp = 1'b0;
    send_frame(8'h01, 8'h02, 8'h04);
    en_at = 0; err_at = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (bus.alu_en && en_at == 0) en_at = n;
      if (bus.err) begin
        err_at = n;
        break;
      end
    end
    check("t5_to_lat", err_at - en_at, TIMEOUT + 1);
    wait_idle("t5_idle");
    check("t5_err", err_cnt - err0, 1);
    check("t5_no_tx", txq.size() - tx0, 0);
    model_resp = 1'b1;

    // Overrun during TX_LO, then reset while in TX_HI.
    tx0 = txq.size(); err0 = err_cnt; model_res = 16'hBEEF; bus.tx_ready = 1'b0;
    send_frame(8'h10, 8'h20, 8'h01);
    tv_at = 0;
    for (int n = 1; n <= 20 && tv_at == 0; n++) begin
      @(negedge clk);
      if (bus.tx_valid) tv_at = n;
    end
    check("t6_txv", {31'd0, bus.tx_valid}, 32'd1);
    @(posedge clk); #1 begin bus.rx_valid = 1'b1; bus.rx_data = 8'h55; end
    @(posedge clk); #1 begin bus.rx_valid = 1'b0; bus.tx_ready = 1'b1; end
    @(posedge clk); #1 bus.tx_ready = 1'b0;
    @(negedge clk);
    check("t6_hi_vld", {31'd0, bus.tx_valid}, 32'd1);
    check("t6_hi_dat", {24'd0, bus.tx_data}, 32'hBE);
    check("t6_ovr_err", err_cnt - err0, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_txv", {31'd0, bus.tx_valid}, 32'd0);
    check("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("t6_rst_a", {24'd0, bus.alu_a}, 32'h00);
    @(posedge clk); #1 rst = 1'b0;
    check("t6_txn", txq.size() - tx0, 1);
    if (txq.size() - tx0 == 1) check("t6_lo", {24'd0, txq[tx0]}, 32'hEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
